// File: rtl/fadd_issue_ctrl.sv
// ---------------------------------------------------------------------------
// fadd_issue_ctrl
// Round-robin issue controller that shares one pipelined fp16 add/sub
// datapath (align -> calc -> normalize) between NREQ requesters.  It owns the
// request handshake, the operand issue register (datapath stage 0), the
// per-stage valid/ID tracking, the global stall and the result return.
// Operand and result data are passed through untouched.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   req_valid/ready     per-requester handshake (at most one ready bit high)
//   req_a, req_b        packed operands, requester i at [16*i+15:16*i]
//   req_sub             per-requester op select (1 = a-b)
//   dp_a, dp_b, dp_sub  issue register outputs into the datapath align stage
//   dp_en               enable for every datapath pipeline register
//   dp_res              datapath result of the op in the last stage
//   res_valid/ready     result handshake
//   res_data, res_id    result value and originating requester index
//
// Optional feature: define FADD_ISSUE_PERF_EN to add the free-running
// counters perf_issue (accepts) and perf_stall (stalled cycles).
// ---------------------------------------------------------------------------
module fadd_issue_ctrl #(
  parameter int NREQ  = 2,
  parameter int IDW   = 1,
  parameter int DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [16*NREQ-1:0] req_a,
  input  logic [16*NREQ-1:0] req_b,
  input  logic [NREQ-1:0]   req_sub,
  output logic [15:0]       dp_a,
  output logic [15:0]       dp_b,
  output logic              dp_sub,
  output logic              dp_en,
  input  logic [15:0]       dp_res,
  output logic              res_valid,
  output logic [15:0]       res_data,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready
`ifdef FADD_ISSUE_PERF_EN
  ,
  output logic [31:0]       perf_issue,
  output logic [31:0]       perf_stall
`endif
);

  logic [DEPTH-1:0] r_v;
  logic [IDW-1:0]   r_id [DEPTH];
  logic [IDW-1:0]   r_rr_ptr;
  logic [15:0]      r_dp_a;
  logic [15:0]      r_dp_b;
  logic             r_dp_sub;

  logic [NREQ-1:0]  w_grant;
  logic [IDW-1:0]   w_gnt_idx;
  logic             w_any;
  logic             w_stall;
  logic             w_dp_en;
  logic             w_accept;
  logic [IDW-1:0]   w_next_ptr;
  logic [15:0]      w_sel_a;
  logic [15:0]      w_sel_b;
  logic             w_sel_sub;

  function automatic logic [IDW-1:0] f_wrap(input int n);
    return IDW'(n % NREQ);
  endfunction

  // Global stall: a held result freezes the whole pipe, bubbles included.
  assign w_stall = r_v[DEPTH-1] & ~res_ready;
  assign w_dp_en = ~w_stall;

  // First valid requester scanning upward from rr_ptr, wrapping at NREQ.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid[f_wrap(int'(r_rr_ptr) + k)]) begin
        w_any     = 1'b1;
        w_gnt_idx = f_wrap(int'(r_rr_ptr) + k);
      end
    end
    if (w_any) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign w_accept   = w_any & w_dp_en;
  assign w_next_ptr = f_wrap(int'(w_gnt_idx) + 1);
  assign w_sel_a    = req_a[16*w_gnt_idx +: 16];
  assign w_sel_b    = req_b[16*w_gnt_idx +: 16];
  assign w_sel_sub  = req_sub[w_gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v      <= '0;
      r_rr_ptr <= '0;
      r_dp_a   <= 16'h0000;
      r_dp_b   <= 16'h0000;
      r_dp_sub <= 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
        r_id[k] <= '0;
      end
    end else if (w_dp_en) begin
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]  <= r_v[k-1];
        r_id[k] <= r_id[k-1];
      end
      r_v[0] <= w_accept;
      if (w_accept) begin
        r_dp_a   <= w_sel_a;
        r_dp_b   <= w_sel_b;
        r_dp_sub <= w_sel_sub;
        r_id[0]  <= w_gnt_idx;
        r_rr_ptr <= w_next_ptr;
      end
    end
  end

  assign req_ready = w_dp_en ? w_grant : '0;
  assign dp_a      = r_dp_a;
  assign dp_b      = r_dp_b;
  assign dp_sub    = r_dp_sub;
  assign dp_en     = w_dp_en;
  assign res_valid = r_v[DEPTH-1];
  assign res_id    = r_id[DEPTH-1];
  assign res_data  = dp_res;

`ifdef FADD_ISSUE_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;

  // Free-running, wrap modulo 2**32.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_issue <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_accept) r_perf_issue <= r_perf_issue + 32'd1;
      if (w_stall)  r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_issue = r_perf_issue;
  assign perf_stall = r_perf_stall;
`endif

endmodule
